sonata_xl_pad_ctrl: RTL and testbench

- Parametrised inout pad controller for Sonata XL-class tops; generalises the fixed I2C/GPIO inout pin map to N pins.
- Sits between peripheral cores (I2C, GPIO, future SPI/PWM inouts) and the top-level pad buffers.
- Output path: registered, with per-pin open-drain or push-pull resolution.
- Input path: per-pin 2-flop synchroniser, programmable glitch filter, and rise/fall event pulses.

---
 rtl/sonata_xl_pad_ctrl.sv | 108 ++++++++++
 tb/tb_sonata_xl_pad_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonata_xl_pad_ctrl.sv
// Inout pad controller: registered OD/PP output resolution, 2-flop input sync, glitch filter, edge events.
// Optional internal loopback of the registered pad drive is built when SONATA_XL_PAD_LOOPBACK_EN is defined.
module sonata_xl_pad_ctrl #(
  parameter int                  NumPins      = 36,
  parameter logic [NumPins-1:0]  OdPinMask    = 36'h0000_0000F,
  parameter logic [NumPins-1:0]  IdleHighMask = 36'h0000_0000F,
  parameter int                  FilterCntW   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef SONATA_XL_PAD_LOOPBACK_EN
  input  logic                  loopback_i,
`endif
  input  logic [FilterCntW-1:0] filter_thresh_i,
  input  logic [NumPins-1:0]    filt_en_i,
  input  logic [NumPins-1:0]    od_en_i,
  input  logic [NumPins-1:0]    core_out_i,
  input  logic [NumPins-1:0]    core_oe_i,
  output logic [NumPins-1:0]    core_in_o,
  output logic [NumPins-1:0]    rise_o,
  output logic [NumPins-1:0]    fall_o,
  input  logic [NumPins-1:0]    pad_in_i,
  output logic [NumPins-1:0]    pad_out_o,
  output logic [NumPins-1:0]    pad_oe_o
);

  localparam logic [FilterCntW-1:0] CntOne = {{(FilterCntW-1){1'b0}}, 1'b1};

  logic [NumPins-1:0]    od;
  logic [NumPins-1:0]    pad_out_d, pad_out_q;
  logic [NumPins-1:0]    pad_oe_d, pad_oe_q;
  logic [NumPins-1:0]    sync1_src;
  logic [NumPins-1:0]    sync1_q, sync2_q;
  logic [NumPins-1:0]    core_in_d, core_in_q;
  logic [NumPins-1:0]    rise_d, rise_q, fall_d, fall_q;
  logic [FilterCntW-1:0] cnt_d [NumPins];
  logic [FilterCntW-1:0] cnt_q [NumPins];

  // Open-drain pins never drive high: they only enable the driver to pull low.
  always_comb begin
    od        = OdPinMask | od_en_i;
    pad_out_d = core_out_i & ~od;
    pad_oe_d  = core_oe_i & ~(od & core_out_i);
  end

`ifdef SONATA_XL_PAD_LOOPBACK_EN
  always_comb begin
    if (loopback_i) begin
      sync1_src = (od & ~pad_oe_q) | (~od & ((pad_oe_q & pad_out_q) | (~pad_oe_q & IdleHighMask)));
    end else begin
      sync1_src = pad_in_i;
    end
  end
  assign pad_oe_o = loopback_i ? '0 : pad_oe_q;
`else
  assign sync1_src = pad_in_i;
  assign pad_oe_o  = pad_oe_q;
`endif

  // A disagreeing level must be seen on thresh+1 consecutive cycles before it is committed.
  always_comb begin
    for (int i = 0; i < NumPins; i++) begin
      core_in_d[i] = core_in_q[i];
      cnt_d[i]     = '0;
      if (!filt_en_i[i]) begin
        core_in_d[i] = sync2_q[i];
      end else if (sync2_q[i] != core_in_q[i]) begin
        if (cnt_q[i] >= filter_thresh_i) begin
          core_in_d[i] = sync2_q[i];
        end else if (cnt_q[i] != '1) begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end
    rise_d = core_in_d & ~core_in_q;
    fall_d = ~core_in_d & core_in_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pad_out_q <= '0;
      pad_oe_q  <= '0;
      sync1_q   <= IdleHighMask;
      sync2_q   <= IdleHighMask;
      core_in_q <= IdleHighMask;
      rise_q    <= '0;
      fall_q    <= '0;
      for (int i = 0; i < NumPins; i++) cnt_q[i] <= '0;
    end else begin
      pad_out_q <= pad_out_d;
      pad_oe_q  <= pad_oe_d;
      sync1_q   <= sync1_src;
      sync2_q   <= sync1_q;
      core_in_q <= core_in_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      for (int i = 0; i < NumPins; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pad_out_o = pad_out_q;
  assign core_in_o = core_in_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;

endmodule

// File: tb/tb_sonata_xl_pad_ctrl.sv
// Directed self-checking bench for sonata_xl_pad_ctrl (default 36-pin map, 8-bit filter).
module tb_sonata_xl_pad_ctrl;

  localparam int          N    = 36;
  localparam logic [35:0] IDLE = 36'h0000_0000F;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    thresh = 8'd0;
  logic [N-1:0]  filt_en = '0;
  logic [N-1:0]  od_en = '0;
  logic [N-1:0]  core_out = '0;
  logic [N-1:0]  core_oe = '0;
  logic [N-1:0]  pad_in = '0;
  logic [N-1:0]  core_in, rise, fall, pad_out, pad_oe;
`ifdef SONATA_XL_PAD_LOOPBACK_EN
  logic          loopback = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sonata_xl_pad_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
`ifdef SONATA_XL_PAD_LOOPBACK_EN
    .loopback_i      (loopback),
`endif
    .filter_thresh_i (thresh),
    .filt_en_i       (filt_en),
    .od_en_i         (od_en),
    .core_out_i      (core_out),
    .core_oe_i       (core_oe),
    .core_in_o       (core_in),
    .rise_o          (rise),
    .fall_o          (fall),
    .pad_in_i        (pad_in),
    .pad_out_o       (pad_out),
    .pad_oe_o        (pad_oe)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] p;
    p = 36'h5_A5A5_A5A3;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      pad_in = (c % 2 == 0) ? '1 : '0;
      tick();
      tests++;
      if (pad_oe !== '0 || pad_out !== '0) begin
        fails++; $display("FAIL reset_pad cyc=%0d oe=%h out=%h want 0", c, pad_oe, pad_out);
      end
      tests++;
      if (core_in !== IDLE) begin
        fails++; $display("FAIL reset_core_in cyc=%0d got %h want %h", c, core_in, IDLE);
      end
      tests++;
      if (rise !== '0 || fall !== '0) begin
        fails++; $display("FAIL reset_events cyc=%0d rise=%h fall=%h want 0", c, rise, fall);
      end
    end
    pad_in = p;
    rst_n  = 1'b1;
    tick();
    tick();
    tests++;
    if (core_in !== IDLE) begin
      fails++; $display("FAIL reset_latency2 got %h want %h", core_in, IDLE);
    end
    tick();
    tests++;
    if (core_in !== p) begin
      fails++; $display("FAIL reset_latency3 got %h want %h", core_in, p);
    end
    tests++;
    if (rise !== (p & ~IDLE) || fall !== (~p & IDLE)) begin
      fails++; $display("FAIL reset_release_events rise=%h fall=%h want %h %h", rise, fall, p & ~IDLE, ~p & IDLE);
    end
  endtask

  task automatic test_output();
    core_oe  = '0;
    core_out = '0;
    core_oe[0] = 1'b1; core_out[0] = 1'b0;
    core_oe[4] = 1'b1; core_out[4] = 1'b1;
    tick();
    tests++;
    if (pad_oe[0] !== 1'b1 || pad_out[0] !== 1'b0) begin
      fails++; $display("FAIL od_drive_low oe=%b out=%b want 1 0", pad_oe[0], pad_out[0]);
    end
    tests++;
    if (pad_oe[4] !== 1'b1 || pad_out[4] !== 1'b1) begin
      fails++; $display("FAIL pp_drive_high oe=%b out=%b want 1 1", pad_oe[4], pad_out[4]);
    end
    core_out[0] = 1'b1;
    #1;
    tests++;
    if (pad_oe[0] !== 1'b1) begin
      fails++; $display("FAIL od_latency oe=%b want 1 before edge", pad_oe[0]);
    end
    tick();
    tests++;
    if (pad_oe[0] !== 1'b0 || pad_out[0] !== 1'b0) begin
      fails++; $display("FAIL od_release oe=%b out=%b want 0 0", pad_oe[0], pad_out[0]);
    end
    od_en[4] = 1'b1;
    tick();
    tests++;
    if (pad_oe[4] !== 1'b0 || pad_out[4] !== 1'b0) begin
      fails++; $display("FAIL od_en_high oe=%b out=%b want 0 0", pad_oe[4], pad_out[4]);
    end
    core_out[4] = 1'b0;
    tick();
    tests++;
    if (pad_oe[4] !== 1'b1 || pad_out[4] !== 1'b0) begin
      fails++; $display("FAIL od_en_low oe=%b out=%b want 1 0", pad_oe[4], pad_out[4]);
    end
    od_en = '0;
    core_oe = '0;
    core_out = '0;
  endtask

  task automatic test_filter();
    pad_in  = '0;
    filt_en = '0;
    thresh  = 8'd3;
    for (int c = 0; c < 5; c++) tick();
    filt_en[5] = 1'b1;
    pad_in[5]  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 3) pad_in[5] = 1'b0;
      tests++;
      if (core_in[5] !== 1'b0 || rise[5] !== 1'b0) begin
        fails++; $display("FAIL filt_reject cyc=%0d core_in=%b rise=%b want 0 0", c, core_in[5], rise[5]);
      end
    end
    pad_in[5] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      tests++;
      if (core_in[5] !== (c >= 6) || rise[5] !== (c == 6) || fall[5] !== 1'b0) begin
        fails++; $display("FAIL filt_pass cyc=%0d core_in=%b rise=%b fall=%b want %b %b 0",
                          c, core_in[5], rise[5], fall[5], c >= 6, c == 6);
      end
    end
  endtask

  task automatic test_bounce();
    thresh     = 8'd5;
    filt_en[7] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      pad_in[7] = (j == 2) ? 1'b0 : 1'b1;
      tick();
      tests++;
      if (core_in[7] !== (j >= 10) || rise[7] !== (j == 10) || fall[7] !== 1'b0) begin
        fails++; $display("FAIL bounce j=%0d core_in=%b rise=%b fall=%b want %b %b 0",
                          j, core_in[7], rise[7], fall[7], j >= 10, j == 10);
      end
    end
  endtask

  task automatic test_thresh_zero();
    thresh     = 8'd0;
    filt_en[8] = 1'b1;
    pad_in[8]  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      tests++;
      if (core_in[8] !== (c >= 3) || rise[8] !== (c == 3)) begin
        fails++; $display("FAIL thresh0 cyc=%0d core_in=%b rise=%b want %b %b", c, core_in[8], rise[8], c >= 3, c == 3);
      end
    end
    pad_in[8] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      tests++;
      if (core_in[8] !== (c < 3) || fall[8] !== (c == 3)) begin
        fails++; $display("FAIL thresh0_fall cyc=%0d core_in=%b fall=%b want %b %b", c, core_in[8], fall[8], c < 3, c == 3);
      end
    end
  endtask

  task automatic test_midreset();
    thresh     = 8'd3;
    filt_en[6] = 1'b1;
    core_oe    = '1;
    pad_in[6]  = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    tests++;
    if (pad_oe !== '1) begin
      fails++; $display("FAIL midreset_pre_oe got %h want all ones", pad_oe);
    end
    pad_in[6] = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    rst_n = 1'b0;
    tick();
    tests++;
    if (pad_oe !== '0 || core_in !== IDLE || rise !== '0 || fall !== '0) begin
      fails++; $display("FAIL midreset oe=%h core_in=%h rise=%h fall=%h want 0 %h 0 0", pad_oe, core_in, rise, fall, IDLE);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      tests++;
      if (core_in[6] !== (c >= 6) || rise[6] !== (c == 6)) begin
        fails++; $display("FAIL midreset_cnt_clear cyc=%0d core_in=%b rise=%b want %b %b", c, core_in[6], rise[6], c >= 6, c == 6);
      end
    end
    core_oe = '0;
    filt_en = '0;
  endtask

`ifdef SONATA_XL_PAD_LOOPBACK_EN
  task automatic test_loopback();
    loopback = 1'b1;
    core_oe  = '0;
    core_out = '0;
    for (int c = 0; c < 6; c++) tick();
    tests++;
    if (core_in[1] !== 1'b1) begin
      fails++; $display("FAIL lb_idle core_in=%b want 1", core_in[1]);
    end
    core_oe[1] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      tests++;
      if (pad_oe[1] !== 1'b0 || core_in[1] !== (c < 4) || fall[1] !== (c == 4)) begin
        fails++; $display("FAIL lb_low cyc=%0d oe=%b core_in=%b fall=%b want 0 %b %b", c, pad_oe[1], core_in[1], fall[1], c < 4, c == 4);
      end
    end
    core_out[1] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      tests++;
      if (core_in[1] !== (c >= 4) || rise[1] !== (c == 4)) begin
        fails++; $display("FAIL lb_high cyc=%0d core_in=%b rise=%b want %b %b", c, core_in[1], rise[1], c >= 4, c == 4);
      end
    end
    loopback = 1'b0;
    core_oe  = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_output();
    test_filter();
    test_bounce();
    test_thresh_zero();
    test_midreset();
`ifdef SONATA_XL_PAD_LOOPBACK_EN
    test_loopback();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
